// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for a qualified lock, then releases dom_rst.
// Define PLL_SEQ_AUTO_RELOCK_EN to re-sequence after lock loss in RUN instead of faulting.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       dom_rst,
    output logic       ready,
    output logic       fault,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       RETRY_MAX    = 8'(MAX_RETRIES);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nx;
    logic [7:0]       retry;
    logic [7:0]       retry_nx;
    logic             sync1;
    logic             locked_s;
    logic             loss;

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1         <= 1'b0;
            locked_s      <= 1'b0;
            state         <= S_RESET_PLL;
            timer         <= '0;
            retry         <= '0;
            pll_rst       <= 1'b1;
            dom_rst       <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            sync1    <= pll_locked;
            locked_s <= sync1;
            state    <= state_nx;
            timer    <= timer_nx;
            retry    <= retry_nx;
            // Outputs decode the next state so they move with the state register
            pll_rst  <= (state_nx == S_RESET_PLL) || (state_nx == S_FAULT);
            dom_rst  <= (state_nx != S_RUN);
            ready    <= (state_nx == S_RUN);
            fault    <= (state_nx == S_FAULT);
            if (loss && (lock_loss_cnt != 8'hFF)) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        retry_nx = retry;
        loss     = 1'b0;
        unique case (state)
            S_RESET_PLL: begin
                if (timer == RST_LAST) begin
                    state_nx = S_WAIT_LOCK;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nx = S_STABLE;
                end else if (timer == TIMEOUT_LAST) begin
                    if (retry == RETRY_MAX) begin
                        state_nx = S_FAULT;
                    end else begin
                        retry_nx = retry + 8'd1;
                        state_nx = S_RESET_PLL;
                    end
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_nx = S_WAIT_LOCK;
                end else if (timer == STABLE_LAST) begin
                    retry_nx = '0;
                    state_nx = S_RUN;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    loss = 1'b1;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
                    retry_nx = '0;
                    state_nx = S_RESET_PLL;
`else
                    state_nx = S_FAULT;
`endif
                end
            end
            S_FAULT: begin
                if (restart) begin
                    retry_nx = '0;
                    state_nx = S_RESET_PLL;
                end
            end
            default: begin
                state_nx = S_RESET_PLL;
            end
        endcase
        if (state_nx != state) begin
            timer_nx = '0;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer with a phase-duration reference model.
// Honours PLL_SEQ_AUTO_RELOCK_EN the same way the design does.
module tb_pll_lock_sequencer;

    localparam int RP = 4;
    localparam int SC = 8;
    localparam int TO = 32;
    localparam int MR = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       dom_rst;
    logic       ready;
    logic       fault;
    logic [7:0] lock_loss_cnt;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES(RP),
        .LOCK_STABLE_CYCLES(SC),
        .LOCK_TIMEOUT_CYCLES(TO),
        .MAX_RETRIES(MR),
        .CNT_W(17)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .restart(restart),
        .pll_rst(pll_rst),
        .dom_rst(dom_rst),
        .ready(ready),
        .fault(fault),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    typedef enum int {PH_RESET, PH_WAIT, PH_STABLE, PH_RUN, PH_FAULT} phase_t;
    typedef struct packed {
        logic [3:0] flags;
        logic [7:0] cnt;
    } exp_t;

    phase_t ph = PH_RESET;
    longint now = 0;
    longint t_enter = 0;
    int     tries = 0;
    int     losses = 0;
    bit     lk[$];
    exp_t   sb[$];
    exp_t   e_mon;
    int     n_checks = 0;
    int     n_fail = 0;

    function automatic void enter(phase_t p);
        ph = p;
        t_enter = now;
    endfunction

    // One rising edge of the reference model; lock is seen two edges late
    task automatic model_edge();
        bit   ls;
        int   spent;
        exp_t e;
        now++;
        if (rst) begin
            enter(PH_RESET);
            tries = 0;
            losses = 0;
            lk = {1'b0, 1'b0};
        end else begin
            ls = lk.pop_front();
            lk.push_back(pll_locked);
            spent = int'(now - t_enter);
            case (ph)
                PH_RESET: if (spent == RP) enter(PH_WAIT);
                PH_WAIT: begin
                    if (ls) enter(PH_STABLE);
                    else if (spent == TO) begin
                        if (tries == MR) enter(PH_FAULT);
                        else begin
                            tries++;
                            enter(PH_RESET);
                        end
                    end
                end
                PH_STABLE: begin
                    if (!ls) enter(PH_WAIT);
                    else if (spent == SC) begin
                        tries = 0;
                        enter(PH_RUN);
                    end
                end
                PH_RUN: begin
                    if (!ls) begin
                        if (losses < 255) losses++;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
                        tries = 0;
                        enter(PH_RESET);
`else
                        enter(PH_FAULT);
`endif
                    end
                end
                PH_FAULT: begin
                    if (restart) begin
                        tries = 0;
                        enter(PH_RESET);
                    end
                end
                default: enter(PH_RESET);
            endcase
        end
        e.flags = {ph == PH_RESET || ph == PH_FAULT, ph != PH_RUN,
                   ph == PH_RUN, ph == PH_FAULT};
        e.cnt = 8'(losses);
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic l, input logic s);
        @(negedge refclk);
        rst = r;
        pll_locked = l;
        restart = s;
        @(posedge refclk);
        model_edge();
    endtask

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always begin
        @(posedge refclk);
        #1;
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            check("flags{pll_rst,dom_rst,ready,fault}",
                  {4'b0, pll_rst, dom_rst, ready, fault}, {4'b0, e_mon.flags});
            check("lock_loss_cnt", lock_loss_cnt, e_mon.cnt);
        end
    end

    initial begin
        // power-up lock at cycle 6
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        repeat (40) step(1'b0, 1'b1, 1'b0);
        // restart ignored in RUN
        repeat (3) step(1'b0, 1'b1, 1'b1);
        // lock drop in RUN
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (40) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b1, 1'b0);
        // lock stuck low through all retries
        step(1'b1, 1'b0, 1'b0);
        repeat (3 * (RP + TO) + 10) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b1, 1'b0);
        // one-cycle glitch while qualifying
        step(1'b1, 1'b1, 1'b0);
        repeat (RP + 2 + 5) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b1, 1'b0);
        // rst during STABLE
        step(1'b1, 1'b1, 1'b0);
        repeat (RP + 4) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        // random traffic
        for (int c = 0; c < 3000; ) begin
            logic lv;
            int   len;
            lv = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                step($urandom_range(0, 499) == 0, lv, $urandom_range(0, 15) == 0);
                c++;
            end
        end
        // 300 lock losses to saturate the counter
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            int w;
            w = 0;
            while (ph != PH_RUN && w < 200) begin
                step(1'b0, 1'b1, ph == PH_FAULT);
                w++;
            end
            if (w >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL reach_run: loop %0d got no RUN within %0d cycles", i, w);
                break;
            end
            repeat (3) step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0);
        @(posedge refclk);
        #2;
        check("lock_loss_cnt_saturated", lock_loss_cnt, 8'd255);
        check("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
